psum_ofifo: RTL

PSUM_OFIFO -- requirements
Module: psum_ofifo

---
 rtl/psum_ofifo_pkg.sv | 14 +
 rtl/psum_fifo_col.sv | 51 +++++
 rtl/psum_ofifo.sv | 58 +++++
 3 files changed

// File: rtl/psum_ofifo_pkg.sv
// Shared defaults and derived widths for the psum output FIFO.
// Column count, psum width and per-column depth live here so every file agrees.
package psum_ofifo_pkg;
   localparam int COL_DEF     = 8;
   localparam int BW_PSUM_DEF = 14;
   localparam int DEPTH_DEF   = 16;

   function automatic int psum_ptr_w(input int d);
      return (d > 1) ? $clog2(d) : 1;
   endfunction

   localparam int PTR_W_DEF = psum_ptr_w(DEPTH_DEF);
   localparam int CNT_W_DEF = PTR_W_DEF + 1;
endpackage

// File: rtl/psum_fifo_col.sv
// One column of the psum output FIFO: circular storage, pointers, count.
// Head is a plain read of the current read pointer; the row register lives in the top.
module psum_fifo_col
   import psum_ofifo_pkg::*;
#(
   parameter int bw_psum = BW_PSUM_DEF,
   parameter int depth   = DEPTH_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [bw_psum-1:0] din,
   input  logic               wr,
   input  logic               pop,
   output logic [bw_psum-1:0] head,
   output logic               full,
   output logic               empty,
   output logic               drop
);
   localparam int PW = psum_ptr_w(depth);
   localparam int CW = PW + 1;

   logic [bw_psum-1:0] mem [depth];
   logic [PW-1:0]      wptr, rptr;
   logic [CW-1:0]      cnt;
   logic               acc;

   assign full  = (cnt == CW'(depth));
   assign empty = (cnt == '0);
   // A full column still takes the write when the row pops in the same cycle.
   assign acc   = wr && (!full || pop);
   assign drop  = wr && !acc;
   assign head  = mem[rptr];

   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (acc) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         if (acc && !pop)      cnt <= cnt + 1'b1;
         else if (pop && !acc) cnt <= cnt - 1'b1;
      end
   end

   // Storage is not reset; entries are only read after being written.
   always_ff @(posedge clk) begin
      if (acc) mem[wptr] <= din;
   end
endmodule

// File: rtl/psum_ofifo.sv
// Row-level psum output FIFO: col independent column FIFOs popped together,
// with a registered output row, a one-cycle out_valid pulse and a sticky overflow flag.
module psum_ofifo
   import psum_ofifo_pkg::*;
#(
   parameter int col     = COL_DEF,
   parameter int bw_psum = BW_PSUM_DEF,
   parameter int depth   = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [col*bw_psum-1:0]   in,
   input  logic [col-1:0]           wr,
   input  logic                     rd,
   output logic                     o_valid,
   output logic                     o_full,
   output logic [col*bw_psum-1:0]   out,
   output logic                     out_valid,
   output logic                     o_overflow
);
   logic [col-1:0]         full, empty, drop;
   logic [col*bw_psum-1:0] head;
   logic                   pop;

   for (genvar i = 0; i < col; i++) begin : g_col
      psum_fifo_col #(
         .bw_psum (bw_psum),
         .depth   (depth)
      ) u_col (
         .clk   (clk),
         .reset (reset),
         .din   (in[i*bw_psum +: bw_psum]),
         .wr    (wr[i]),
         .pop   (pop),
         .head  (head[i*bw_psum +: bw_psum]),
         .full  (full[i]),
         .empty (empty[i]),
         .drop  (drop[i])
      );
   end

   // Flags come from the counts as they stand before this edge's update.
   assign o_valid = ~|empty;
   assign o_full  = |full;
   assign pop     = rd && o_valid;

   always_ff @(posedge clk) begin
      if (!reset) begin
         out        <= '0;
         out_valid  <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         out_valid <= pop;
         if (pop)   out        <= head;
         if (|drop) o_overflow <= 1'b1;
      end
   end
endmodule
